// File: rtl/seq_detect4_pkg.sv
// rtl/seq_detect4_pkg.sv - state encodings, widths and KMP fallback table builder for seq_detect4
package seq_detect4_pkg;

  localparam int ST_W = 3;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_M1   = 3'd1,
    ST_M2   = 3'd2,
    ST_M3   = 3'd3,
    ST_HIT  = 3'd4
  } state_t;

  // Entry {k, bit} (k = bits matched, 0..4) holds the longest suffix of
  // (matched prefix + bit) that is also a prefix of pat; a full match yields k+1.
  function automatic logic [29:0] kmp_table(input logic [3:0] pat);
    logic [29:0] tbl;
    logic [4:0]  seq;
    int          len;
    int          best;
    logic        ok;
    tbl = '0;
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 2; b++) begin
        seq = '0;
        for (int i = 0; i < 4; i++) begin
          if (i < k) seq[i] = pat[3-i];
        end
        seq[k] = b[0];
        len  = k + 1;
        best = 0;
        for (int j = 1; j <= 4; j++) begin
          if (j <= len) begin
            ok = 1'b1;
            for (int m = 0; m < 4; m++) begin
              if (m < j && seq[len-j+m] != pat[3-m]) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
        tbl[(k*2+b)*3 +: 3] = best[2:0];
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_detect4_if.sv
// rtl/seq_detect4_if.sv - serial input, count control and status bundle for seq_detect4
interface seq_detect4_if
  import seq_detect4_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic             din_valid;
  logic             din;
  logic             cnt_clr;
  logic             detect;
  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output din_valid, din, cnt_clr,
    input  detect, state, match_cnt, cnt_sat
  );

  modport slave (
    input  din_valid, din, cnt_clr,
    output detect, state, match_cnt, cnt_sat
  );

endinterface

// File: rtl/seq_detect4_sat_counter.sv
// rtl/seq_detect4_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (inc && !sat) cnt_nxt = cnt + W'(1);
  end

  // sat is registered from the next count so it rises with the count reaching max
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= &cnt_nxt;
    end
  end

endmodule

// File: rtl/seq_detect4.sv
// rtl/seq_detect4.sv - serial Moore 4-bit pattern detector; SEQ_DETECT_OVERLAP_EN enables overlapping matches
module seq_detect4
  import seq_detect4_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
  parameter int         CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_detect4_if.slave bus
);

  localparam logic [29:0] KMP = kmp_table(PATTERN);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] row;
  logic       legal;
  logic       hit_entry;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row       = 3'd0;
    legal     = 1'b1;
    case (state)
      ST_IDLE, ST_M1, ST_M2, ST_M3: row = state;
`ifdef SEQ_DETECT_OVERLAP_EN
      ST_HIT:                       row = 3'd4;
`else
      ST_HIT:                       row = 3'd0;
`endif
      default:                      legal = 1'b0;
    endcase
    // Illegal encodings recover to IDLE even while the input is stalled
    if (!legal)             state_nxt = ST_IDLE;
    else if (bus.din_valid) state_nxt = state_t'(KMP[int'({row, bus.din})*3 +: 3]);
  end

  assign hit_entry = bus.din_valid && legal && (state_nxt == ST_HIT);
  assign bus.detect = (state == ST_HIT);
  assign bus.state  = state;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (hit_entry),
    .cnt   (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect4.sv
// tb/tb_seq_detect4.sv - randomized and directed check of seq_detect4 against a history-based model
module tb_seq_detect4;

  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  seq_detect4_if #(.CNT_W(8)) bus8();
  seq_detect4_if #(.CNT_W(2)) bus2();

  seq_detect4 #(.PATTERN(PAT), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_detect4 #(.PATTERN(PAT), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  bit hist[$];
  int m_state = 0;
  int m_cnt8  = 0;
  int m_cnt2  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Longest tail of the received history that equals the head of the pattern
  function automatic int match_len();
    int best = 0;
    int n = hist.size();
    for (int j = 1; j <= 4; j++) begin
      if (j <= n) begin
        bit ok = 1'b1;
        for (int m = 0; m < j; m++)
          if (hist[n-j+m] != PAT[3-m]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  task automatic step(input bit rst, input bit v, input bit d, input bit clr8, input bit clr2);
    bit hit;
    @(negedge clk);
    reset = rst;
    bus8.din_valid = v;  bus2.din_valid = v;
    bus8.din = d;        bus2.din = d;
    bus8.cnt_clr = clr8; bus2.cnt_clr = clr2;
    @(posedge clk);
    hit = 1'b0;
    if (rst) begin
      hist.delete();
      m_state = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (v) begin
`ifndef SEQ_DETECT_OVERLAP_EN
        if (m_state == 4) hist.delete();
`endif
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        m_state = match_len();
        hit = (m_state == 4);
      end
      if (clr8) m_cnt8 = 0; else if (hit && m_cnt8 < 255) m_cnt8++;
      if (clr2) m_cnt2 = 0; else if (hit && m_cnt2 < 3) m_cnt2++;
    end
    #1;
    check("state8",  32'(bus8.state),     32'(m_state));
    check("detect8", 32'(bus8.detect),    32'(m_state == 4));
    check("cnt8",    32'(bus8.match_cnt), 32'(m_cnt8));
    check("sat8",    32'(bus8.cnt_sat),   32'(m_cnt8 == 255));
    check("state2",  32'(bus2.state),     32'(m_state));
    check("cnt2",    32'(bus2.match_cnt), 32'(m_cnt2));
    check("sat2",    32'(bus2.cnt_sat),   32'(m_cnt2 == 3));
  endtask

  task automatic send(input bit d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] s3;
    logic [3:0] pv;
    int exp_st[4];
    int pulses;
    bit prev;
    int exp_pulses;

    reset = 1'b1;
    bus8.din_valid = 1'b0; bus8.din = 1'b0; bus8.cnt_clr = 1'b0;
    bus2.din_valid = 1'b0; bus2.din = 1'b0; bus2.cnt_clr = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_state", 32'(bus8.state), 32'd0);
    check("t1_detect", 32'(bus8.detect), 32'd0);
    check("t1_cnt", 32'(bus8.match_cnt), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_state_b", 32'(bus8.state), 32'd0);

    // Back-to-back 1011
    exp_st = '{1, 2, 3, 4};
    pv = PAT;
    for (int i = 0; i < 4; i++) begin
      send(pv[3-i]);
      check("t2_state", 32'(bus8.state), 32'(exp_st[i]));
    end
    check("t2_detect", 32'(bus8.detect), 32'd1);
    check("t2_cnt", 32'(bus8.match_cnt), 32'd1);

    // 1011011: overlap gives two pulses, default gives one
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s3 = 7'b1011011;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(s3[6-i]);
      if (bus8.detect && !prev) pulses++;
      prev = bus8.detect;
    end
`ifdef SEQ_DETECT_OVERLAP_EN
    exp_pulses = 2;
`else
    exp_pulses = 1;
`endif
    check("t3_pulses", 32'(pulses), 32'(exp_pulses));
    check("t3_cnt", 32'(bus8.match_cnt), 32'(exp_pulses));

    // Stall in the middle of the pattern
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1);
    send(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'(i & 1), 1'b0, 1'b0);
      check("t4_stall", 32'(bus8.state), 32'd2);
    end
    send(1'b1);
    send(1'b1);
    check("t4_state", 32'(bus8.state), 32'd4);
    check("t4_cnt", 32'(bus8.match_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_park", 32'(bus8.detect), 32'd1);
    check("t4_park_cnt", 32'(bus8.match_cnt), 32'd1);

    // Reset mid-pattern
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1); send(1'b0); send(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_reset", 32'(bus8.state), 32'd0);
    send(1'b1);
    check("t5_state", 32'(bus8.state), 32'd1);

    // 2-bit counter saturation, then clear on a HIT entry
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) send(pv[3-i]);
      check("t6_cnt2", 32'(bus2.match_cnt), 32'(n + 1));
      check("t6_sat2", 32'(bus2.cnt_sat), 32'(n == 2));
    end
    send(1'b1); send(1'b0); send(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_clr_cnt2", 32'(bus2.match_cnt), 32'd0);
    check("t6_clr_sat2", 32'(bus2.cnt_sat), 32'd0);
    check("t6_cnt8", 32'(bus8.match_cnt), 32'd4);

    // Random traffic with stalls, clears and occasional resets
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 299) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
